hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 20 ++
 rtl/hazard_unit_md_sequencer.sv | 62 ++++++
 rtl/hazard_unit.sv | 88 ++++++++
 3 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared pipeline encodings for the hazard unit: forwarding selects,
// mul/div sequencer states and a register-match helper.
package hazard_unit_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  // A write to r0 is architecturally discarded, so it never matches a source.
  function automatic logic reg_hit(input logic en, input logic [4:0] dst,
                                   input logic [4:0] src);
    return en && (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_unit_md_sequencer.sv
// Mul/div occupancy sequencer: counts execute-stage cycles of a multiply or
// divide and pulses done on the last one.
module md_sequencer
  import hazard_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  md_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // A start seen while busy (including the done cycle) is dropped; the
  // pipeline re-presents it once the sequencer is back in IDLE.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = BUSY;
          cnt_n   = is_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt == '0) begin
          done    = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: execute/decode operand forwarding, load-use, branch
// and mul/div stalls, plus the mul/div occupancy sequencer.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic       branch_d,
  input  logic       mdstart_d,
  input  logic       mdread_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] writereg_e,
  input  logic       regwrite_e,
  input  logic       memtoreg_e,
  input  logic       mdstart_e,
  input  logic       md_is_div_e,
  input  logic [4:0] writereg_m,
  input  logic       regwrite_m,
  input  logic       memtoreg_m,
  input  logic [4:0] writereg_w,
  input  logic       regwrite_w,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_e,
  output logic [1:0] forward_a_e,
  output logic [1:0] forward_b_e,
  output logic       forward_a_d,
  output logic       forward_b_d,
  output logic       md_busy,
  output logic       md_done
);

  localparam int NUM_OPS = 2;

  logic [NUM_OPS-1:0][4:0] src_e, src_d;
  logic [NUM_OPS-1:0][1:0] fwd_e;
  logic [NUM_OPS-1:0]      fwd_d, br_hit;
  logic                    lwstall, brstall, mdstall, stall;

  assign src_e = {rt_e, rs_e};
  assign src_d = {rt_d, rs_d};

  // Operand 0 is A (rs), operand 1 is B (rt); memory stage wins over writeback.
  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    always_comb begin
      fwd_e[i] = FWD_NONE;
      if (reg_hit(regwrite_m, writereg_m, src_e[i]))      fwd_e[i] = FWD_MEM;
      else if (reg_hit(regwrite_w, writereg_w, src_e[i])) fwd_e[i] = FWD_WB;
    end
    assign fwd_d[i]  = reg_hit(regwrite_m, writereg_m, src_d[i]);
    assign br_hit[i] = reg_hit(regwrite_e, writereg_e, src_d[i]) ||
                       reg_hit(memtoreg_m, writereg_m, src_d[i]);
  end

  assign forward_a_e = fwd_e[0];
  assign forward_b_e = fwd_e[1];
  assign forward_a_d = fwd_d[0];
  assign forward_b_d = fwd_d[1];

  md_sequencer #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_seq (
    .clk   (clk),
    .reset (reset),
    .start (mdstart_e),
    .is_div(md_is_div_e),
    .busy  (md_busy),
    .done  (md_done)
  );

  // During reset the sequencer is treated as idle so a stale BUSY cannot stall.
  assign lwstall = memtoreg_e && ((rt_e == rs_d) || (rt_e == rt_d));
  assign brstall = branch_d && (|br_hit);
  assign mdstall = md_busy && !reset && (mdstart_d || mdread_d);
  assign stall   = lwstall || brstall || mdstall;

  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;

endmodule
